// File: rtl/sum_accumulator.sv
// Batched reduction stage behind the 2-bit adder: sums COUNT accepted samples
// and presents the total plus a sticky overflow flag on a registered valid/ready port.
module sum_accumulator #(
   parameter int unsigned COUNT     = 4,
   parameter int unsigned ACC_WIDTH = 8
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 clear,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [2:0]           in_sum,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ACC_WIDTH-1:0] out_total,
   output logic                 out_overflow
);

   localparam int unsigned      CNT_W    = (COUNT > 1) ? $clog2(COUNT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);

   logic [ACC_WIDTH-1:0] acc_q, acc_d;
   logic                 ovf_q, ovf_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [ACC_WIDTH-1:0] total_q, total_d;
   logic                 oovf_q, oovf_d;
   logic                 valid_q, valid_d;

   logic [ACC_WIDTH:0]   sum_ext;
   logic                 accept;
   logic                 batch_close;

   always_comb begin
      in_ready    = ~clear & (~valid_q | out_ready);
      accept      = in_valid & in_ready;
      sum_ext     = {1'b0, acc_q} + {{(ACC_WIDTH-2){1'b0}}, in_sum};
      batch_close = accept & (cnt_q == CNT_LAST);

      acc_d   = acc_q;
      ovf_d   = ovf_q;
      cnt_d   = cnt_q;
      total_d = total_q;
      oovf_d  = oovf_q;
      valid_d = valid_q;

      if (clear) begin
         acc_d   = '0;
         ovf_d   = 1'b0;
         cnt_d   = '0;
         total_d = '0;
         oovf_d  = 1'b0;
         valid_d = 1'b0;
      end else begin
         // A drain and a batch close in the same cycle keep valid high with new data.
         if (valid_q & out_ready) valid_d = 1'b0;
         if (batch_close) begin
            total_d = sum_ext[ACC_WIDTH-1:0];
            oovf_d  = ovf_q | sum_ext[ACC_WIDTH];
            valid_d = 1'b1;
            acc_d   = '0;
            ovf_d   = 1'b0;
            cnt_d   = '0;
         end else if (accept) begin
            acc_d = sum_ext[ACC_WIDTH-1:0];
            ovf_d = ovf_q | sum_ext[ACC_WIDTH];
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         acc_q   <= '0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
         total_q <= '0;
         oovf_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         ovf_q   <= ovf_d;
         cnt_q   <= cnt_d;
         total_q <= total_d;
         oovf_q  <= oovf_d;
         valid_q <= valid_d;
      end
   end

   assign out_valid    = valid_q;
   assign out_total    = total_q;
   assign out_overflow = oovf_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// Scoreboard bench for sum_accumulator: three instances cover COUNT=4/W=8,
// COUNT=4/W=4 (overflow) and COUNT=1 (single-sample batches).
module tb_sum_accumulator;

   typedef struct {
      logic [7:0] total;
      logic       ovf;
   } exp_t;

   logic       clock;
   logic       reset_n;
   logic       clr [3];
   logic       iv  [3];
   logic [2:0] sum [3];
   logic       orr [3];
   logic       ir  [3];
   logic       ov  [3];
   logic       oovf[3];
   logic [7:0] tot [3];
   logic [7:0] tot_a;
   logic [3:0] tot_b;
   logic [7:0] tot_c;

   exp_t q0[$];
   exp_t q1[$];
   exp_t q2[$];

   int n_checks = 0;
   int n_fail   = 0;

   sum_accumulator #(.COUNT(4), .ACC_WIDTH(8)) dut_a (
      .clock(clock), .reset_n(reset_n), .clear(clr[0]), .in_valid(iv[0]),
      .in_ready(ir[0]), .in_sum(sum[0]), .out_valid(ov[0]), .out_ready(orr[0]),
      .out_total(tot_a), .out_overflow(oovf[0]));

   sum_accumulator #(.COUNT(4), .ACC_WIDTH(4)) dut_b (
      .clock(clock), .reset_n(reset_n), .clear(clr[1]), .in_valid(iv[1]),
      .in_ready(ir[1]), .in_sum(sum[1]), .out_valid(ov[1]), .out_ready(orr[1]),
      .out_total(tot_b), .out_overflow(oovf[1]));

   sum_accumulator #(.COUNT(1), .ACC_WIDTH(8)) dut_c (
      .clock(clock), .reset_n(reset_n), .clear(clr[2]), .in_valid(iv[2]),
      .in_ready(ir[2]), .in_sum(sum[2]), .out_valid(ov[2]), .out_ready(orr[2]),
      .out_total(tot_c), .out_overflow(oovf[2]));

   assign tot[0] = tot_a;
   assign tot[1] = {4'b0000, tot_b};
   assign tot[2] = tot_c;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic push(input int id, input logic [7:0] t, input logic o);
      exp_t e;
      e.total = t;
      e.ovf   = o;
      case (id)
         0:       q0.push_back(e);
         1:       q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endtask

   // Presents one sample and waits (bounded) for its handshake edge.
   task automatic send(input int id, input logic [2:0] s, output int stalls);
      logic taken;
      logic done;
      stalls  = 0;
      done    = 1'b0;
      iv[id]  = 1'b1;
      sum[id] = s;
      for (int k = 0; k < 50 && !done; k++) begin
         #1;
         taken = ir[id];
         cycle();
         if (taken) done = 1'b1;
         else stalls++;
      end
      if (!done) chk("send_timeout", 0, 1);
      iv[id] = 1'b0;
   endtask

   // Monitor: pops an expectation on every output handshake.
   always @(negedge clock) begin
      exp_t e;
      logic got;
      if (reset_n) begin
         for (int i = 0; i < 3; i++) begin
            if (ov[i] && orr[i]) begin
               got = 1'b0;
               case (i)
                  0: if (q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
                  1: if (q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
                  default: if (q2.size() > 0) begin e = q2.pop_front(); got = 1'b1; end
               endcase
               if (!got) chk("sb_unexpected_output", 1, 0);
               else begin
                  chk("sb_total", tot[i], e.total);
                  chk("sb_ovf", oovf[i], e.ovf);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int st;
      int stall_sum;
      for (int i = 0; i < 3; i++) begin
         clr[i] = 1'b0; iv[i] = 1'b0; sum[i] = '0; orr[i] = 1'b1;
      end
      reset_n = 1'b0;
      repeat (3) cycle();
      reset_n = 1'b1;
      #1;
      chk("reset_in_ready", ir[0], 1);
      chk("reset_out_valid", ov[0], 0);
      chk("reset_out_total", tot[0], 0);
      chk("reset_out_ovf", oovf[0], 0);
      cycle();

      // Pending result wiped by asynchronous reset without a clock edge.
      orr[0] = 1'b0;
      send(0, 3'd5, st); send(0, 3'd5, st); send(0, 3'd5, st); send(0, 3'd5, st);
      chk("pending_valid", ov[0], 1);
      chk("pending_total", tot[0], 20);
      reset_n = 1'b0;
      #1;
      chk("async_rst_valid", ov[0], 0);
      chk("async_rst_total", tot[0], 0);
      cycle();
      reset_n = 1'b1;
      orr[0]  = 1'b1;
      cycle();

      // Partial batch discarded by reset, then 1,2,3,0 -> 6 with one-cycle latency.
      send(0, 3'd1, st); send(0, 3'd2, st);
      reset_n = 1'b0;
      cycle();
      reset_n = 1'b1;
      cycle();
      push(0, 8'd6, 1'b0);
      send(0, 3'd1, st); chk("lat_valid_1", ov[0], 0);
      send(0, 3'd2, st); chk("lat_valid_2", ov[0], 0);
      send(0, 3'd3, st); chk("lat_valid_3", ov[0], 0);
      send(0, 3'd0, st); chk("lat_valid_4", ov[0], 1);
      cycle();
      chk("drained_valid", ov[0], 0);

      // Streaming: two batches back to back, no stall.
      push(0, 8'd24, 1'b0);
      push(0, 8'd10, 1'b0);
      stall_sum = 0;
      send(0, 3'd6, st); stall_sum += st;
      send(0, 3'd6, st); stall_sum += st;
      send(0, 3'd6, st); stall_sum += st;
      send(0, 3'd6, st); stall_sum += st;
      chk("stream_first_total", tot[0], 24);
      send(0, 3'd1, st); stall_sum += st;
      send(0, 3'd2, st); stall_sum += st;
      send(0, 3'd3, st); stall_sum += st;
      send(0, 3'd4, st); stall_sum += st;
      chk("stream_stalls", stall_sum, 0);
      chk("stream_second_total", tot[0], 10);
      cycle();

      // Overflow on 4-bit accumulator; flag must not carry into the next batch.
      push(1, 8'd8, 1'b1);
      push(1, 8'd4, 1'b0);
      send(1, 3'd6, st); send(1, 3'd6, st); send(1, 3'd6, st); send(1, 3'd6, st);
      send(1, 3'd1, st); send(1, 3'd1, st); send(1, 3'd1, st); send(1, 3'd1, st);
      cycle();

      // Back-pressure: result 24 held, inputs blocked, then released.
      orr[0] = 1'b0;
      push(0, 8'd24, 1'b0);
      push(0, 8'd20, 1'b0);
      send(0, 3'd6, st); send(0, 3'd6, st); send(0, 3'd6, st); send(0, 3'd6, st);
      iv[0]  = 1'b1;
      sum[0] = 3'd5;
      for (int k = 0; k < 5; k++) begin
         chk("bp_in_ready", ir[0], 0);
         chk("bp_total_held", tot[0], 24);
         chk("bp_valid_held", ov[0], 1);
         cycle();
      end
      orr[0] = 1'b1;
      #1;
      chk("bp_release_ready", ir[0], 1);
      cycle();
      iv[0] = 1'b0;
      send(0, 3'd5, st); send(0, 3'd5, st); send(0, 3'd5, st);
      cycle();

      // Clear mid-batch blocks the sample and restarts the batch.
      send(0, 3'd5, st); send(0, 3'd5, st);
      clr[0] = 1'b1;
      iv[0]  = 1'b1;
      sum[0] = 3'd7;
      #1;
      chk("clear_in_ready", ir[0], 0);
      cycle();
      clr[0] = 1'b0;
      iv[0]  = 1'b0;
      push(0, 8'd4, 1'b0);
      send(0, 3'd1, st); send(0, 3'd1, st); send(0, 3'd1, st); send(0, 3'd1, st);
      cycle();

      // Clear discards a pending result.
      orr[0] = 1'b0;
      send(0, 3'd2, st); send(0, 3'd2, st); send(0, 3'd2, st); send(0, 3'd2, st);
      chk("clr_pending_valid", ov[0], 1);
      clr[0] = 1'b1;
      cycle();
      clr[0] = 1'b0;
      chk("clr_valid_dropped", ov[0], 0);
      chk("clr_total_zeroed", tot[0], 0);
      orr[0] = 1'b1;

      // COUNT=1: each sample is its own batch, valid stays high.
      push(2, 8'd3, 1'b0);
      push(2, 8'd6, 1'b0);
      push(2, 8'd0, 1'b0);
      stall_sum = 0;
      send(2, 3'd3, st); stall_sum += st;
      chk("c1_valid_a", ov[2], 1); chk("c1_total_a", tot[2], 3);
      send(2, 3'd6, st); stall_sum += st;
      chk("c1_valid_b", ov[2], 1); chk("c1_total_b", tot[2], 6);
      send(2, 3'd0, st); stall_sum += st;
      chk("c1_valid_c", ov[2], 1); chk("c1_total_c", tot[2], 0);
      chk("c1_stalls", stall_sum, 0);

      repeat (4) cycle();
      chk("sb_left_dut_a", q0.size(), 0);
      chk("sb_left_dut_b", q1.size(), 0);
      chk("sb_left_dut_c", q2.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
